// File: rtl/bcd_seg_if.sv
// Upstream/display bundle for bcd_seg_scanner: packed BCD strobe in, multiplexed segment drive out.
interface bcd_seg_if;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output bcd, bcd_valid,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  bcd, bcd_valid,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/bcd_seg_scanner.sv
// Four-digit common-anode 7-segment scanner with tear-free frame-boundary commit of BCD updates.
// Optional: define SEG_BLANK_LEADING_ZEROS_EN to blank leading zero digits (ones digit always shown).
module bcd_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    bcd_seg_if.slave   bus
);

    localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       pend_q, pend_d;
    logic              pend_flag_q, pend_flag_d;
    logic [15:0]       disp_q, disp_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              frame_done_q, frame_done_d;

    logic              tick_c;
    logic              wrap_c;
    logic [3:0]        digit_c;
    logic [3:0]        blank_c;

    // Active-high {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        tick_c = (tick_cnt_q == TICK_W'(REFRESH_DIV - 1));
        wrap_c = tick_c && (idx_q == 2'd3);

        case (idx_q)
            2'd0:    digit_c = disp_q[3:0];
            2'd1:    digit_c = disp_q[7:4];
            2'd2:    digit_c = disp_q[11:8];
            default: digit_c = disp_q[15:12];
        endcase

        blank_c = 4'b0000;
`ifdef SEG_BLANK_LEADING_ZEROS_EN
        // Blank from the thousands down until the first nonzero committed digit.
        blank_c[3] = (disp_q[15:12] == 4'd0);
        blank_c[2] = blank_c[3] && (disp_q[11:8] == 4'd0);
        blank_c[1] = blank_c[2] && (disp_q[7:4] == 4'd0);
`endif
    end

    always_comb begin
        tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        idx_d        = tick_c ? idx_q + 2'd1 : idx_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        disp_d       = disp_q;
        frame_done_d = wrap_c;

        // A strobe landing on the wrap tick bypasses the pending buffer.
        if (wrap_c) begin
            pend_flag_d = 1'b0;
            if (bus.bcd_valid) begin
                pend_d = bus.bcd;
                disp_d = bus.bcd;
            end else if (pend_flag_q) begin
                disp_d = pend_q;
            end
        end else if (bus.bcd_valid) begin
            pend_d      = bus.bcd;
            pend_flag_d = 1'b1;
        end

        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank_c[idx_q] ? 7'h7F : ~seg_decode(digit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q   <= '0;
            idx_q        <= 2'd0;
            pend_q       <= 16'h0000;
            pend_flag_q  <= 1'b0;
            disp_q       <= 16'h0000;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_done_q;

endmodule
